// File: rtl/disp_scan_ctrl.sv
// Multiplexed 6-digit seven-segment scan controller: register port, paced digit scan
// with guard interval, leading-zero suppression, per-digit blank and blink masks.
module disp_scan_ctrl #(
  parameter int DIGITS    = 6,
  parameter int PRESCALE  = 1000,
  parameter int GUARD     = 1,
  parameter int BLINK_DIV = 64
) (
  input  logic       CLK,
  input  logic       RSTN,
  input  logic       WR_EN,
  input  logic [3:0] WR_ADDR,
  input  logic [5:0] WR_DATA,
  input  logic       ZS,
  output logic [2:0] SEL,
  output logic [5:0] DIG_N,
  output logic [6:0] SEG,
  output logic       FRAME
);

  localparam int PW = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
  localparam int FW = (BLINK_DIV > 1) ? $clog2(BLINK_DIV) : 1;
  localparam logic [2:0] LAST_SEL = 3'(DIGITS - 1);

  logic [PW-1:0] presc, presc_nx;
  logic [FW-1:0] fcnt, fcnt_nx;
  logic          phase, phase_nx;
  logic [2:0]    sel_nx;
  logic          frame_nx;
  logic          presc_wrap;
  logic [3:0]    digit [DIGITS];
  logic [5:0]    blank, blink;
  logic [5:0]    supp;
  logic          zero_above;
  logic          lit;
  logic [5:0]    dig_nx;
  logic [6:0]    seg_nx;

  function automatic logic [6:0] decode(input logic [3:0] v);
    logic [6:0] s;
    case (v)
      4'h0:    s = 7'b0111111;
      4'h1:    s = 7'b0000110;
      4'h2:    s = 7'b1011011;
      4'h3:    s = 7'b1001111;
      4'h4:    s = 7'b1100110;
      4'h5:    s = 7'b1101101;
      4'h6:    s = 7'b1111101;
      4'h7:    s = 7'b0000111;
      4'h8:    s = 7'b1111111;
      4'h9:    s = 7'b1101111;
      4'hA:    s = 7'b1110111;
      4'hB:    s = 7'b1111100;
      4'hC:    s = 7'b0111001;
      4'hD:    s = 7'b1011110;
      4'hE:    s = 7'b1111001;
      default: s = 7'b1110001;
    endcase
    return s;
  endfunction

  // Outputs are derived from the post-edge scan position and blink phase so that
  // DIG_N/SEG switch on the same edge as SEL; register contents are the pre-edge ones.
  always_comb begin
    presc_wrap = (presc == PW'(PRESCALE - 1));
    presc_nx   = presc_wrap ? '0 : presc + 1'b1;
    frame_nx   = 1'b0;
    sel_nx     = SEL;
    if (SEL > LAST_SEL) begin
      sel_nx = '0;
    end else if (presc_wrap) begin
      if (SEL == LAST_SEL) begin
        sel_nx   = '0;
        frame_nx = 1'b1;
      end else begin
        sel_nx = SEL + 1'b1;
      end
    end

    fcnt_nx  = fcnt;
    phase_nx = phase;
    if (frame_nx) begin
      if (fcnt == FW'(BLINK_DIV - 1)) begin
        fcnt_nx  = '0;
        phase_nx = ~phase;
      end else begin
        fcnt_nx = fcnt + 1'b1;
      end
    end

    supp       = '0;
    zero_above = 1'b1;
    for (int unsigned i = DIGITS - 1; i >= 1; i--) begin
      zero_above = zero_above && (digit[i] == 4'h0);
      supp[i]    = zero_above;
    end

    lit = (presc_nx >= PW'(GUARD)) && !blank[sel_nx] &&
          !(blink[sel_nx] && phase_nx) && !(ZS && supp[sel_nx]);

    dig_nx = lit ? ~(6'b000001 << sel_nx) : '1;
    seg_nx = lit ? decode(digit[sel_nx]) : '0;
  end

  always_ff @(posedge CLK or negedge RSTN) begin
    if (!RSTN) begin
      presc <= '0;
      fcnt  <= '0;
      phase <= 1'b0;
      SEL   <= '0;
      DIG_N <= '1;
      SEG   <= '0;
      FRAME <= 1'b0;
    end else begin
      presc <= presc_nx;
      fcnt  <= fcnt_nx;
      phase <= phase_nx;
      SEL   <= sel_nx;
      DIG_N <= dig_nx;
      SEG   <= seg_nx;
      FRAME <= frame_nx;
    end
  end

  always_ff @(posedge CLK or negedge RSTN) begin
    if (!RSTN) begin
      for (int unsigned i = 0; i < DIGITS; i++) digit[i] <= '0;
      blank <= '0;
      blink <= '0;
    end else if (WR_EN) begin
      if (WR_ADDR < 4'd6)       digit[WR_ADDR[2:0]] <= WR_DATA[3:0];
      else if (WR_ADDR == 4'd6) blank <= WR_DATA;
      else if (WR_ADDR == 4'd7) blink <= WR_DATA;
    end
  end

endmodule

// File: doc/disp_scan_ctrl.md
Name: disp_scan_ctrl

Overview:
Scan controller for the 6-digit multiplexed seven-segment display. Holds per-digit hex values plus blank and blink masks written over a simple register port. Paces the digit-select scan with a prescaler and inserts a guard (all-off) interval at each digit change to suppress ghosting. Drives the active-low digit enables and the decoded segment pattern that go to the display pins.

Parameters:
DIGITS, 6, number of scanned digits; fixed at 6 for this board, bounds SEL to 0..5.
PRESCALE, 1000, CLK cycles per digit slot; must be >= 2.
GUARD, 1, cycles at the start of each slot with all digits off; must be < PRESCALE.
BLINK_DIV, 64, full scan frames per blink half-period; must be >= 1.

Ports:
CLK  input  1  system clock, all state on rising edge.
RSTN  input  1  asynchronous active-low reset.
WR_EN  input  1  register write strobe, sampled on CLK rising edge.
WR_ADDR  input  4  0-5 = digit value regs, 6 = blank mask, 7 = blink mask, 8-15 = ignored.
WR_DATA  input  6  write data; digit regs take [3:0], mask regs take [5:0].
ZS  input  1  leading-zero suppression enable, level, evaluated every cycle.
SEL  output  3  index of the digit slot currently scanned, 0..5.
DIG_N  output  6  active-low digit enables; bit i low only when digit i is lit.
SEG  output  7  segment pattern {g,f,e,d,c,b,a}, active-high.
FRAME  output  1  one-cycle pulse when SEL wraps from 5 to 0.

Behaviour:
- Reset (RSTN low, async, no clock needed): SEL=0, DIG_N=6'b111111, SEG=7'b0000000, FRAME=0. Prescaler, frame counter, blink phase, six digit regs, blank mask and blink mask all cleared. Outputs hold until RSTN deasserts. Reset mid-slot aborts the slot immediately.
- Prescaler: counts 0..PRESCALE-1 and wraps. On the edge where it wraps, SEL advances by 1; 5 wraps to 0. Any SEL value > 5 is forced to 0 on the next edge.
- FRAME: high for exactly the one cycle in which SEL has just become 0 via wrap. It is not pulsed on reset exit.
- All outputs are registered, with no skew. DIG_N and SEG are computed from the post-edge SEL and prescaler values, so they change on the same edge as SEL.
- Digit SEL is lit when all of the following hold:
  - prescaler >= GUARD;
  - blank[SEL] = 0;
  - not (blink[SEL] = 1 and blink phase = 1);
  - not suppressed.
- When digit SEL is lit: DIG_N = all ones except bit SEL = 0, and SEG = decode(digit[SEL]). When it is not lit: DIG_N = 6'b111111 and SEG = 7'b0000000.
- Leading-zero suppression (ZS=1): digit 5 is the most significant. Digit i, for i in 1..5, is suppressed when digit[i]=0 and every digit[j]=0 for j>i. Digit 0 is never suppressed.
- Decode table (hex, gfedcba):
  - 0=0111111, 1=0000110, 2=1011011, 3=1001111
  - 4=1100110, 5=1101101, 6=1111101, 7=0000111
  - 8=1111111, 9=1101111, A=1110111, b=1111100
  - C=0111001, d=1011110, E=1111001, F=1110001
- Blink: the frame counter counts FRAME pulses 0..BLINK_DIV-1. Each time it wraps, the blink phase toggles. Phase 0 = shown, phase 1 = dark for masked digits.
- Writes:
  - WR_EN=1 updates the addressed register on that edge. The display reflects the new value from the following edge onward, including mid-slot.
  - Writes to addresses 8-15 are discarded with no side effect.
  - Back-to-back writes every cycle are allowed.
  - The scan never stalls for writes.

Test Plan:
(Bench parameters: PRESCALE=4, GUARD=1, BLINK_DIV=2.)
1. Release reset, no writes. SEL steps 0,1,2,3,4,5,0 every 4 clocks. In each slot DIG_N is 111111 for 1 clock, then bit SEL is low for 3 clocks; SEG=0111111 while a digit is lit. FRAME pulses once per 24 clocks, on the cycle SEL returns to 0.
2. Write digits 0..5 = 1,2,3,4,5,F. Slot 0 lit phase: SEG=0000110, DIG_N=111110. Slot 5 lit phase: SEG=1110001, DIG_N=011111.
3. Write blank mask 6'b000100. During slot 2, DIG_N=111111 and SEG=0 for all 4 clocks; the other slots are unchanged.
4. Set ZS=1 and digits 5..0 = 0,0,0,1,0,7. Slots 5, 4 and 3 stay dark. Slot 2 shows 0000110. Slot 1 shows 0111111 (embedded zero, lit). Slot 0 shows 0000111.
5. Write blink mask 6'b000001. Digit 0 is lit in frames 0-1, dark in frames 2-3, and lit again in frames 4-5.
6. Drop RSTN low mid-slot 3 between clock edges. SEL=0, DIG_N=111111 and SEG=0 immediately. After release, all digits show 0 and the masks are clear.
